// File: rtl/temp_sensor_target_if.sv
// Purpose: bus-side signal bundle of the temperature-sensor target (two-wire bus plus sensor word and status).
// Latency: none; this is wiring only.
// Backpressure: none; the bus is clocked by the initiator and the target only acknowledges or releases SDA.
interface temp_sensor_target_if;
  logic        scl;
  logic        sda_in;
  logic        sda_oe;
  logic [15:0] temp_data;
  logic        busy;
  logic        rd_done;

  // initiator / environment side
  modport master (
    output scl,
    output sda_in,
    output temp_data,
    input  sda_oe,
    input  busy,
    input  rd_done
  );

  // target side
  modport slave (
    input  scl,
    input  sda_in,
    input  temp_data,
    output sda_oe,
    output busy,
    output rd_done
  );
endinterface

// File: rtl/temp_sensor_target.sv
// Purpose: read-only two-wire bus target that returns a 16-bit temperature word, MSB first, streaming while ACKed.
// Latency: SYNC_STAGES+1 clk from a bus edge to its detection; SDA drive updates one clk after a detected SCL fall.
// Backpressure: none; the initiator paces every bit through SCL and ends a read by NACK and STOP.
module temp_sensor_target #(
  parameter logic [6:0] DEV_ADDR    = 7'b1001000,
  parameter int         SYNC_STAGES = 2            // legal range 2..3
) (
  input  logic                 clk,
  input  logic                 reset,
  temp_sensor_target_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    TX_MSB,
    ACK_MSB,
    TX_LSB,
    ACK_LSB,
    WAIT_STOP
  } state_t;

  // synchronizers and edge detection
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  // transaction state
  state_t      state;
  state_t      state_nxt;
  logic [3:0]  bit_cnt;
  logic [3:0]  bit_cnt_nxt;
  logic [7:0]  shift;
  logic [7:0]  shift_nxt;
  logic [15:0] shadow;
  logic [15:0] shadow_nxt;
  logic        sda_oe_q;
  logic        sda_oe_nxt;
  logic        busy_q;
  logic        busy_nxt;
  logic        rd_done_q;
  logic        rd_done_nxt;

  // datapath helpers
  logic [7:0]  addr_byte;
  logic        addr_match;
  logic [3:0]  tx_idx;
  logic        tx_bit;

  // Bring SCL/SDA into the clk domain; flops idle high like a released bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s &  scl_prev;
  // SDA may only move while SCL is high at START/STOP boundaries.
  assign start_det = scl_s &  sda_prev & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev &  sda_s;

  // The byte as it will look once the bit on this SCL rise is shifted in.
  assign addr_byte  = {shift[6:0], sda_s};
  assign addr_match = (addr_byte[7:1] == DEV_ADDR) && addr_byte[0];

  // TX_MSB walks shadow[15:8], TX_LSB walks shadow[7:0]; 7-bit_cnt is ~bit_cnt[2:0].
  assign tx_idx = {(state == TX_MSB), ~bit_cnt[2:0]};
  assign tx_bit = shadow[tx_idx];

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      shadow    <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      shadow    <= shadow_nxt;
      sda_oe_q  <= sda_oe_nxt;
      busy_q    <= busy_nxt;
      rd_done_q <= rd_done_nxt;
    end
  end

  // Next-state and output logic; START/STOP outrank any SCL edge seen in the same cycle.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    shadow_nxt  = shadow;
    sda_oe_nxt  = sda_oe_q;
    busy_nxt    = busy_q;
    rd_done_nxt = 1'b0;

    if (stop_det) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else if (start_det) begin
      // also covers repeated START in the middle of a read
      state_nxt   = ADDR;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_nxt = addr_byte;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt = '0;
              if (addr_match) begin
                state_nxt  = ACK_ADDR;
                shadow_nxt = bus.temp_data;
                busy_nxt   = 1'b1;
              end else begin
                // foreign address or write: never touch SDA, just wait it out
                state_nxt = WAIT_STOP;
              end
            end else begin
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end

        ACK_ADDR: begin
          // first fall starts the ACK low; second fall ends it and puts out shadow[15]
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_oe_nxt  = 1'b1;
              bit_cnt_nxt = 4'd1;
            end else begin
              state_nxt   = TX_MSB;
              sda_oe_nxt  = ~shadow[15];
              bit_cnt_nxt = 4'd1;
            end
          end
        end

        TX_MSB, TX_LSB: begin
          // bit_cnt counts bits already placed on SDA in this byte
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = (state == TX_MSB) ? ACK_MSB : ACK_LSB;
            end else begin
              sda_oe_nxt  = ~tx_bit;
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end

        ACK_MSB: begin
          sda_oe_nxt = 1'b0;
          if (scl_rise) begin
            bit_cnt_nxt = '0;
            if (!sda_s) begin
              state_nxt = TX_LSB;
            end else begin
              state_nxt = WAIT_STOP;
              busy_nxt  = 1'b0;
            end
          end
        end

        ACK_LSB: begin
          sda_oe_nxt = 1'b0;
          if (scl_rise) begin
            rd_done_nxt = 1'b1;
            bit_cnt_nxt = '0;
            if (!sda_s) begin
              // initiator wants more: take a fresh sample for the next word
              shadow_nxt = bus.temp_data;
              state_nxt  = TX_MSB;
            end else begin
              state_nxt = WAIT_STOP;
              busy_nxt  = 1'b0;
            end
          end
        end

        WAIT_STOP: begin
          sda_oe_nxt = 1'b0;
          busy_nxt   = 1'b0;
        end

        default: begin
          // IDLE: only a START (handled above) moves us on
          sda_oe_nxt = 1'b0;
          busy_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_oe  = sda_oe_q;
  assign bus.busy    = busy_q;
  assign bus.rd_done = rd_done_q;

endmodule

// File: doc/temp_sensor_target.md
TEMP_SENSOR_TARGET -- requirements
Module: temp_sensor_target

Interface
REQ-001 Parameter DEV_ADDR, 7'b1001000, 7-bit bus address the block responds to.
REQ-002 Parameter SYNC_STAGES, 2, flops in each input synchronizer chain (legal 2..3).
REQ-003 clk  input  1  system clock; all logic on rising edge; at least 8x the SCL rate.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low (0 = reset asserted).
REQ-005 scl  input  1  bus clock from initiator, asynchronous to clk.
REQ-006 sda_in  input  1  sampled bus data line, asynchronous to clk.
REQ-007 sda_oe  output  1  open-drain pull-down enable: 1 = drive SDA low, 0 = release SDA.
REQ-008 temp_data  input  16  temperature word to return, MSB first.
REQ-009 busy  output  1  high from address match until the transaction ends.
REQ-010 rd_done  output  1  one-clk pulse each time a full 16-bit word has been shifted out.

Function
REQ-011 scl and sda_in pass through SYNC_STAGES flops; edges are detected on the synchronized copies (scl_rise, scl_fall); no logic uses the raw inputs.
REQ-012 START = synchronized SDA falling while synchronized SCL high; STOP = synchronized SDA rising while synchronized SCL high.
REQ-013 States: IDLE, ADDR, ACK_ADDR, TX_MSB, ACK_MSB, TX_LSB, ACK_LSB, WAIT_STOP.
REQ-014 START from any state -> ADDR, with bit counter cleared and sda_oe = 0 (repeated start supported).
REQ-015 STOP from any state -> IDLE, sda_oe = 0, busy = 0.
REQ-016 ADDR: shift synchronized SDA into an 8-bit register on each scl_rise, MSB first; after the 8th bit go to ACK_ADDR.
REQ-017 Match = byte[7:1] == DEV_ADDR and byte[0] == 1 (read); on mismatch or write bit go to WAIT_STOP with SDA released (NACK).
REQ-018 On match: capture temp_data into a 16-bit shadow register in the same cycle; set busy; drive sda_oe = 1 from the following scl_fall through the next scl_fall (ACK bit).
REQ-019 TX_MSB / TX_LSB: on each scl_fall, set sda_oe = ~(next shadow bit), so a 0 bit pulls low and a 1 bit releases; 8 bits per state, sent shadow[15] first.
REQ-020 sda_oe changes only in the clk cycle after a detected scl_fall, never while synchronized SCL is high (except START/STOP release).
REQ-021 ACK_MSB / ACK_LSB: release SDA on scl_fall; sample initiator's bit on scl_rise; 0 = ACK, 1 = NACK.
REQ-022 ACK_MSB: ACK -> TX_LSB; NACK -> WAIT_STOP.
REQ-023 rd_done pulses for exactly one clk on the scl_rise that samples the ACK_LSB bit, regardless of ACK/NACK.
REQ-024 ACK_LSB: ACK -> re-capture temp_data into shadow, then TX_MSB (continuous streaming); NACK -> WAIT_STOP.
REQ-025 WAIT_STOP: SDA released, ignore SCL edges; leave only on START or STOP; busy is cleared on entry.
REQ-026 temp_data changes outside the capture cycles of REQ-018/REQ-024 do not affect the word in flight.
REQ-027 START and STOP detection take priority over any SCL edge detected in the same cycle.

Reset
REQ-028 While reset = 0: state = IDLE, sda_oe = 0, busy = 0, rd_done = 0, shift/shadow/bit counter = 0, synchronizer flops = 1 (idle-high bus).
REQ-029 Reset asserted mid-transaction immediately releases SDA; after deassertion the block waits in IDLE for a new START.

Verification
REQ-030 Reset, then START, address byte 8'b10010001, temp_data = 16'hA455 -> ACK (sda_oe = 1 on 9th SCL), SDA bits 1010_0100, released for initiator ACK, then 0101_0101; rd_done single pulse; after NACK and STOP, busy = 0.
REQ-031 Address byte 8'b10010011 (wrong address) -> no ACK, sda_oe = 0 for the whole transfer, busy = 0, state WAIT_STOP until STOP.
REQ-032 Address byte 8'b10010000 (write to own address) -> NACK, sda_oe stays 0, no rd_done.
REQ-033 ACK after LSB with temp_data changed to 16'h1234 during first word -> second word is 16'h1234, first word unaltered (16'hA455); two rd_done pulses.
REQ-034 Initiator NACK after MSB byte -> SDA released, no LSB bits driven, no rd_done; repeated START with address 8'b10010001 -> fresh ACK and transfer.
REQ-035 reset pulled low during 5th data bit while sda_oe = 1 -> sda_oe = 0 asynchronously; after release, SCL toggling without START produces no ACK and no drive.
